// File: rtl/xge_wb_arbiter.sv
// Two-master round-robin arbiter in front of a single Wishbone-style register slave.
// Each transaction is one BUS phase followed by a one-cycle RESP phase.
// A slave that never acks is cut off after ACK_TIMEOUT wb_valid cycles and reported as an error.
module xge_wb_arbiter #(
    parameter int unsigned ACK_TIMEOUT = 8
) (
    input  logic        clk_156,
    input  logic        rst,
    input  logic        m0_req,
    input  logic        m0_we,
    input  logic [7:0]  m0_addr,
    input  logic [31:0] m0_wdata,
    output logic        m0_ack,
    output logic        m0_err,
    output logic [31:0] m0_rdata,
    input  logic        m1_req,
    input  logic        m1_we,
    input  logic [7:0]  m1_addr,
    input  logic [31:0] m1_wdata,
    output logic        m1_ack,
    output logic        m1_err,
    output logic [31:0] m1_rdata,
    output logic        wb_valid,
    output logic        wb_we,
    output logic [7:0]  wb_addr,
    output logic [31:0] wb_wdata,
    input  logic [31:0] wb_rdata,
    input  logic        wb_ack,
    output logic [1:0]  grant,
    output logic [7:0]  timeout_cnt
);

    localparam int unsigned ADDR_W = 8;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned CNT_W  = 8;

    localparam logic [CNT_W-1:0] TIMEOUT_LIM = CNT_W'(ACK_TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_MAX     = '1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUS  = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    logic [1:0]        state_q,       state_d;
    logic              ptr_q,         ptr_d;
    logic [1:0]        grant_q,       grant_d;
    logic              wb_valid_q,    wb_valid_d;
    logic              wb_we_q,       wb_we_d;
    logic [ADDR_W-1:0] wb_addr_q,     wb_addr_d;
    logic [DATA_W-1:0] wb_wdata_q,    wb_wdata_d;
    logic [CNT_W-1:0]  wait_q,        wait_d;
    logic [CNT_W-1:0]  timeout_cnt_q, timeout_cnt_d;
    logic              m0_ack_q,      m0_ack_d;
    logic              m1_ack_q,      m1_ack_d;
    logic              m0_err_q,      m0_err_d;
    logic              m1_err_q,      m1_err_d;
    logic [DATA_W-1:0] m0_rdata_q,    m0_rdata_d;
    logic [DATA_W-1:0] m1_rdata_q,    m1_rdata_d;

    logic              win_c;
    logic              single_c;
    logic              owner_c;

    // Next-state and registered-output computation
    always_comb begin
        state_d       = state_q;
        ptr_d         = ptr_q;
        grant_d       = grant_q;
        wb_valid_d    = wb_valid_q;
        wb_we_d       = wb_we_q;
        wb_addr_d     = wb_addr_q;
        wb_wdata_d    = wb_wdata_q;
        wait_d        = wait_q;
        timeout_cnt_d = timeout_cnt_q;
        m0_ack_d      = 1'b0;
        m1_ack_d      = 1'b0;
        m0_err_d      = 1'b0;
        m1_err_d      = 1'b0;
        m0_rdata_d    = '0;
        m1_rdata_d    = '0;
        win_c         = 1'b0;
        single_c      = m0_req ^ m1_req;
        owner_c       = grant_q[1];

        case (state_q)
            IDLE: begin
                if (m0_req || m1_req) begin
                    // Contention goes to the preferred master, otherwise to the sole requester
                    win_c      = (m0_req && m1_req) ? ptr_q : m1_req;
                    grant_d    = win_c ? 2'b10 : 2'b01;
                    wb_valid_d = 1'b1;
                    wb_we_d    = win_c ? m1_we    : m0_we;
                    wb_addr_d  = win_c ? m1_addr  : m0_addr;
                    wb_wdata_d = win_c ? m1_wdata : m0_wdata;
                    wait_d     = CNT_W'(1);
                    // A lone request from the already-preferred master leaves the pointer alone
                    if (!(single_c && (win_c == ptr_q))) begin
                        ptr_d = ~win_c;
                    end
                    state_d    = BUS;
                end
            end

            BUS: begin
                if (wb_ack) begin
                    state_d    = RESP;
                    wb_valid_d = 1'b0;
                    if (owner_c) begin
                        m1_ack_d   = 1'b1;
                        m1_rdata_d = wb_we_q ? '0 : wb_rdata;
                    end else begin
                        m0_ack_d   = 1'b1;
                        m0_rdata_d = wb_we_q ? '0 : wb_rdata;
                    end
                end else if (wait_q == TIMEOUT_LIM) begin
                    state_d    = RESP;
                    wb_valid_d = 1'b0;
                    if (owner_c) begin
                        m1_err_d = 1'b1;
                    end else begin
                        m0_err_d = 1'b1;
                    end
                    if (timeout_cnt_q != CNT_MAX) begin
                        timeout_cnt_d = timeout_cnt_q + CNT_W'(1);
                    end
                end else begin
                    wait_d = wait_q + CNT_W'(1);
                end
            end

            RESP: begin
                // Requests are not sampled here; the bus is released for one IDLE cycle
                state_d    = IDLE;
                grant_d    = 2'b00;
                wb_we_d    = 1'b0;
                wb_addr_d  = '0;
                wb_wdata_d = '0;
                wait_d     = '0;
            end

            default: begin
                state_d    = IDLE;
                grant_d    = 2'b00;
                wb_valid_d = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk_156) begin
        if (rst) begin
            state_q       <= IDLE;
            ptr_q         <= 1'b0;
            grant_q       <= 2'b00;
            wb_valid_q    <= 1'b0;
            wb_we_q       <= 1'b0;
            wb_addr_q     <= '0;
            wb_wdata_q    <= '0;
            wait_q        <= '0;
            timeout_cnt_q <= '0;
            m0_ack_q      <= 1'b0;
            m1_ack_q      <= 1'b0;
            m0_err_q      <= 1'b0;
            m1_err_q      <= 1'b0;
            m0_rdata_q    <= '0;
            m1_rdata_q    <= '0;
        end else begin
            state_q       <= state_d;
            ptr_q         <= ptr_d;
            grant_q       <= grant_d;
            wb_valid_q    <= wb_valid_d;
            wb_we_q       <= wb_we_d;
            wb_addr_q     <= wb_addr_d;
            wb_wdata_q    <= wb_wdata_d;
            wait_q        <= wait_d;
            timeout_cnt_q <= timeout_cnt_d;
            m0_ack_q      <= m0_ack_d;
            m1_ack_q      <= m1_ack_d;
            m0_err_q      <= m0_err_d;
            m1_err_q      <= m1_err_d;
            m0_rdata_q    <= m0_rdata_d;
            m1_rdata_q    <= m1_rdata_d;
        end
    end

    assign grant       = grant_q;
    assign wb_valid    = wb_valid_q;
    assign wb_we       = wb_we_q;
    assign wb_addr     = wb_addr_q;
    assign wb_wdata    = wb_wdata_q;
    assign timeout_cnt = timeout_cnt_q;
    assign m0_ack      = m0_ack_q;
    assign m1_ack      = m1_ack_q;
    assign m0_err      = m0_err_q;
    assign m1_err      = m1_err_q;
    assign m0_rdata    = m0_rdata_q;
    assign m1_rdata    = m1_rdata_q;

endmodule

// File: doc/xge_wb_arbiter.md
XGE_WB_ARBITER -- requirements
Module: xge_wb_arbiter

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset.
REQ-002 The block SHALL have parameter ACK_TIMEOUT, default 8, giving the maximum number of wb_valid cycles to wait for wb_ack (legal range 1..255).
REQ-003 The block SHALL have these ports (name direction width meaning):
- clk_156  in  1   156.25 MHz core clock; all logic sampled on its rising edge
- rst  in  1   synchronous active-high reset
- m0_req / m1_req  in  1   master request; held until the matching ack/err
- m0_we / m1_we  in  1   write enable
- m0_addr / m1_addr  in  8   register address
- m0_wdata / m1_wdata  in  32   write data
- m0_ack / m1_ack  out  1   one-cycle completion pulse
- m0_err / m1_err  out  1   one-cycle timeout pulse
- m0_rdata / m1_rdata  out  32   read data; valid while the matching ack is high
- wb_valid  out  1   slave cycle/strobe
- wb_we  out  1   slave write enable
- wb_addr  out  8   slave address
- wb_wdata  out  32   slave write data
- wb_rdata  in  32   slave read data
- wb_ack  in  1   slave acknowledge
- grant  out  2   one-hot owner of the slave bus; 2'b00 when no master owns it
- timeout_cnt  out  8   saturating count of timed-out transactions

Function
REQ-004 The FSM SHALL have exactly three states: IDLE, BUS and RESP.
REQ-005 In IDLE with any mN_req high at edge N, the block SHALL register the winning master's we/addr/wdata, set grant, and enter BUS, so that wb_valid is high from cycle N+1.
REQ-006 Arbitration SHALL be round-robin through a 1-bit pointer: on simultaneous requests the master not served last wins; after reset, m0 wins.
REQ-007 The pointer SHALL update only when a grant is issued, and never on a single-requester grant to the already-preferred master.
REQ-008 In BUS, wb_valid, wb_we, wb_addr and wb_wdata SHALL hold constant and SHALL NOT follow changes on the master inputs.
REQ-009 In BUS, an 8-bit wait counter SHALL start at 1 on the first wb_valid cycle and increment on each later cycle.
REQ-010 When wb_ack is sampled high in BUS, the block SHALL capture wb_rdata and enter RESP.
REQ-011 When wb_ack has not been sampled high by the edge on which the wait counter equals ACK_TIMEOUT, the block SHALL enter RESP flagged as an error.
REQ-012 In RESP (one cycle), wb_valid SHALL be 0, grant SHALL be held, and the owner's ack (success) or err (timeout) SHALL be 1 for exactly that cycle; ack and err SHALL never be high together.
REQ-013 On a timeout, timeout_cnt SHALL increment in RESP and saturate at 255.
REQ-014 RESP SHALL always go to IDLE and SHALL ignore requests; the earliest new wb_valid is therefore 3 cycles after the ack edge.
REQ-015 mN_rdata SHALL equal the captured wb_rdata during ack and SHALL be 0 on err and on writes.
REQ-016 wb_ack sampled while wb_valid is 0 (stray ack) SHALL be ignored with no state change.
REQ-017 If the owner drops its req during BUS, the transaction SHALL still complete and the ack/err SHALL still pulse.
REQ-018 The non-owner's ack and err SHALL stay 0 throughout.

Reset
REQ-019 While rst is high at an edge, the next state SHALL be IDLE with wb_valid, wb_we, wb_addr, wb_wdata, grant, all ack/err/rdata and timeout_cnt at 0 and the pointer preferring m0.
REQ-020 A reset asserted mid-BUS SHALL abort the transaction with no ack or err pulse to either master.

Verification
REQ-021 The bench SHALL cover: m0 read of addr 8'h10 with ack on the 3rd wb_valid cycle and wb_rdata 32'hCAFE_0001 -> m0_ack one cycle with m0_rdata 32'hCAFE_0001 and m1_ack 0.
REQ-022 The bench SHALL cover: m0 and m1 requesting on the same edge, both held for 3 transactions each -> grant order m0,m1,m0,m1,m0,m1.
REQ-023 The bench SHALL cover: with ACK_TIMEOUT=8, m1 write with the slave never acking -> exactly 8 wb_valid cycles, then m1_err one cycle and timeout_cnt 1.
REQ-024 The bench SHALL cover: 300 forced timeouts -> timeout_cnt stays 255.
REQ-025 The bench SHALL cover: m0_addr changed from 8'h20 to 8'h24 during BUS -> wb_addr stays 8'h20 until RESP.
REQ-026 The bench SHALL cover: rst pulsed on the 2nd BUS cycle, and separately a stray wb_ack in IDLE -> wb_valid 0 next cycle with no ack/err pulse, grant 0; the stray ack causes no output change.
